neopixel_msg_fifo: RTL
======================

NEOPIXEL_MSG_FIFO -- requirements
Module: neopixel_msg_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of entries; power of two, range 2 to 256.
REQ-002 SHALL have parameter ADDR_W, default 4: log2(DEPTH).
REQ-003 SHALL have port clk  input  1: single system clock, 20 MHz, shared with the transmitter FSM.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1: host push strobe, one entry per high cycle.
REQ-006 SHALL have port wr_data  input  24: GRB color word, G7 is bit 23.
REQ-007 SHALL have port wr_msgTyp  input  1: 1 = color message, 0 = reset (latch) message.
REQ-008 SHALL have port flush  input  1: synchronous clear of all entries.
REQ-009 SHALL have port rd_next  input  1: read strobe from the transmitter; may stay high for more than one cycle.
REQ-010 SHALL have port empty_flg  output  1: high when no entry is held.
REQ-011 SHALL have port neo_dIn  output  24: GRB data of the head entry.
REQ-012 SHALL have port rgb_msgTyp  output  1: message type of the head entry.
REQ-013 SHALL have port full_flg  output  1: high when DEPTH entries are held.
REQ-014 SHALL have port level  output  ADDR_W+1: number of entries held.
REQ-015 SHALL have port ovf_err  output  1: sticky flag, set by a push while full.
REQ-016 SHALL have port udf_err  output  1: sticky flag, set by a pop request while empty.

Function
REQ-017 SHALL operate as a show-ahead FIFO: while empty_flg is low, neo_dIn and rgb_msgTyp SHALL present the oldest entry with no read latency.
REQ-018 SHALL store each entry as 25 bits, {wr_msgTyp, wr_data}, captured on the rising clk edge where wr_en is high.
REQ-019 SHALL form the pop request as rd_next high with its 1-cycle-delayed copy low (rising-edge detect), so one strobe of any length pops exactly one entry.
REQ-020 SHALL advance the read pointer on the same edge that samples the pop request, so the next head is valid in the following cycle.
REQ-021 SHALL deassert empty_flg in the cycle after the write edge of an entry pushed into an empty FIFO (write-to-visible latency of 1 cycle).
REQ-022 SHALL, on a simultaneous push and pop with 1 to DEPTH-1 entries held, perform both and leave level unchanged.
REQ-023 SHALL, on a simultaneous push and pop while empty, accept the push, ignore the pop, and set udf_err.
REQ-024 SHALL, on a simultaneous push and pop while full, perform the pop, accept the push, and leave ovf_err unchanged.
REQ-025 SHALL, on a push while full with no pop, drop the entry, set ovf_err, and leave storage and pointers unchanged.
REQ-026 SHALL, on a pop request while empty, leave pointers unchanged and set udf_err.
REQ-027 SHALL, on flush high, zero the pointers and level and clear ovf_err and udf_err; flush SHALL take priority over push and pop in the same cycle.
REQ-028 SHALL use ADDR_W-bit pointers that wrap modulo DEPTH; full_flg SHALL be level == DEPTH and empty_flg SHALL be level == 0.
REQ-029 SHALL present the head entry on neo_dIn and rgb_msgTyp while empty_flg is high (outputs are don't-care, but SHALL hold no X after reset).

Reset
REQ-030 SHALL, while rst is low, force pointers = 0, level = 0, empty_flg = 1, full_flg = 0, ovf_err = 0, udf_err = 0, and the rd_next delay register = 0.
REQ-031 SHALL reset the storage array to all zeros, so neo_dIn = 0 and rgb_msgTyp = 0 after reset.
REQ-032 SHALL discard all held entries on a reset asserted mid-operation; no pop SHALL be generated on the first edge after release, even if rd_next is high at that edge.

Structure
REQ-033 SHALL take MSG_RESET = 1'b0, MSG_RGB = 1'b1, the 24-bit color width, and the 25-bit entry width from the shared neopixel definitions include file.
REQ-034 SHALL place storage in one sub-module, neopixel_msg_ram: DEPTH x 25, one synchronous write port, one asynchronous read port; all pointer and flag logic SHALL stay in neopixel_msg_fifo.

Verification
REQ-035 SHALL verify: after reset, push 0xFF0000/RGB, 0x00FF00/RGB, then a reset message; three 2-cycle rd_next strobes SHALL pop exactly three entries, in order, with types 1, 1, 0.
REQ-036 SHALL verify: push 17 entries with DEPTH=16; the result SHALL be full_flg = 1, level = 16, ovf_err = 1, and the 17th entry absent on drain.
REQ-037 SHALL verify: a 5-cycle rd_next strobe while empty SHALL leave level = 0 and set udf_err = 1 after one cycle.
REQ-038 SHALL verify: with level = 8, push and pop in the same cycle SHALL leave level = 8; and pushing 40 entries while continuously popping SHALL exercise pointer wrap with data intact.
REQ-039 SHALL verify: flush and wr_en high in the same cycle SHALL give level = 0, empty_flg = 1, and both error flags cleared.
REQ-040 SHALL verify: with the FIFO connected to the transmitter FSM (mode = 1), 4 color entries followed by 1 reset message SHALL produce a 96-bit serial stream followed by a 51 us low, then empty_flg = 1.

Source files
------------

// File: rtl/neopixel_msg_fifo_pkg.sv
// Shared NeoPixel message definitions: message type encodings, color and
// entry widths, and the packed layout of one queued message.
package neopixel_msg_fifo_pkg;

  localparam int COLOR_W = 24;
  localparam int ENTRY_W = COLOR_W + 1;

  // Message type: a color word to shift out, or a latch (reset) gap.
  localparam logic MSG_RESET = 1'b0;
  localparam logic MSG_RGB   = 1'b1;

  // One queued message, stored as {msg_typ, color}.
  typedef struct packed {
    logic               msg_typ;
    logic [COLOR_W-1:0] color;
  } entry_t;

endpackage

// File: rtl/neopixel_msg_ram.sv
// Message storage: DEPTH x ENTRY_W, one synchronous write port and one
// asynchronous read port so the FIFO head is visible without read latency.
module neopixel_msg_ram
  import neopixel_msg_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Write one entry per enabled edge; clear all entries on reset.
  // NOTE: the array is reset on purpose so the head outputs are zero (never X)
  // while the FIFO is empty after reset; this costs a reset on every storage flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/neopixel_msg_fifo.sv
// Show-ahead message FIFO between the host and the NeoPixel transmitter.
// Pops are generated on the rising edge of rd_next, so a strobe of any
// length consumes exactly one entry. Overflow/underflow are sticky flags.
module neopixel_msg_fifo
  import neopixel_msg_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               wr_msgTyp,
  input  logic               flush,
  input  logic               rd_next,
  output logic               empty_flg,
  output logic [COLOR_W-1:0] neo_dIn,
  output logic               rgb_msgTyp,
  output logic               full_flg,
  output logic [ADDR_W:0]    level,
  output logic               ovf_err,
  output logic               udf_err
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              rd_next_q, rd_next_d;
  logic              armed_q, armed_d;

  logic   is_empty, is_full, pop_req, do_push, do_pop, ram_we;
  entry_t wr_entry, head;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == FULL_LEVEL);

  // armed_q is low only on the first edge after reset release, so an rd_next
  // already high at release is not mistaken for a fresh strobe.
  assign pop_req = rd_next & ~rd_next_q & armed_q;
  // A pop frees a slot in the same edge, so a full FIFO still accepts a push
  // that coincides with a pop.
  assign do_push = wr_en & (~is_full | pop_req);
  assign do_pop  = pop_req & ~is_empty;
  assign ram_we  = do_push & ~flush;

  assign wr_entry = '{msg_typ: wr_msgTyp, color: wr_data};

  // Next-state for pointers, level and sticky error flags; flush wins.
  // NOTE: every *_d gets its hold value first so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    rd_next_d = rd_next;
    armed_d   = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (do_pop && !do_push) level_d = level_q - 1'b1;
      if (wr_en && is_full && !pop_req) ovf_d = 1'b1;
      if (pop_req && is_empty)          udf_d = 1'b1;
    end
  end

  // State registers.
  // NOTE: non-blocking assignments here so every flop samples the values from
  // before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_next_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      rd_next_q <= rd_next_d;
      armed_q   <= armed_d;
    end
  end

  neopixel_msg_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  assign neo_dIn    = head.color;
  assign rgb_msgTyp = head.msg_typ;
  assign empty_flg  = is_empty;
  assign full_flg   = is_full;
  assign level      = level_q;
  assign ovf_err    = ovf_q;
  assign udf_err    = udf_q;

endmodule
